unpooler: RTL and testbench

- Inverse of the pooling stage: nearest-neighbour upsampler for CNN decoder paths.
- Consumes a raster stream of an (M/P)×(M/P) pooled map.
- Emits an M×M raster stream with each input value replicated over its P×P window.
- Line buffer holds one pooled row so it can be replayed for the remaining P-1 output rows.

---
 rtl/unpool_pkg.sv | 27 ++
 rtl/unpooler_if.sv | 38 +++
 rtl/unpool_line_buf.sv | 26 ++
 rtl/unpooler.sv | 146 ++++++++++++++
 tb/tb_unpooler.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/unpool_pkg.sv
// unpool_pkg: shared geometry defaults, counter-width helper, FSM states and
// the line-buffer entry type used by the unpooler (max-unpool: UNPOOL_ARGMAX_EN).
package unpool_pkg;

    localparam int DEF_M  = 4;
    localparam int DEF_P  = 2;
    localparam int DEF_DW = 16;
    localparam int N      = DEF_M / DEF_P;

    // Counter width for a range of values, never less than one bit.
    function automatic int cw(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

    localparam int IDX_W = cw(DEF_P * DEF_P);

    typedef enum logic [0:0] {
        FILL   = 1'b0,
        REPLAY = 1'b1
    } state_e;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DEF_DW-1:0] value;
    } entry_t;

endpackage

// File: rtl/unpooler_if.sv
// unpooler_if: pooled input stream (data_in/in_valid/in_ready[/idx_in]) and
// upsampled output stream (data_out/valid_op/out_ready/end_op). Macro: UNPOOL_ARGMAX_EN.
interface unpooler_if
    import unpool_pkg::*;
#(
    parameter int DW = DEF_DW
);
    logic [DW-1:0] data_in;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] data_out;
    logic          valid_op;
    logic          out_ready;
    logic          end_op;

`ifdef UNPOOL_ARGMAX_EN
    logic [IDX_W-1:0] idx_in;

    modport master (
        output data_in, in_valid, idx_in, out_ready,
        input  in_ready, data_out, valid_op, end_op
    );
    modport slave (
        input  data_in, in_valid, idx_in, out_ready,
        output in_ready, data_out, valid_op, end_op
    );
`else
    modport master (
        output data_in, in_valid, out_ready,
        input  in_ready, data_out, valid_op, end_op
    );
    modport slave (
        input  data_in, in_valid, out_ready,
        output in_ready, data_out, valid_op, end_op
    );
`endif

endinterface

// File: rtl/unpool_line_buf.sv
// unpool_line_buf: one pooled row of entries; synchronous write, async read.
// Ports: clk, we/wr_idx/wr_data (write side), rd_idx/rd_data (read side).
module unpool_line_buf
    import unpool_pkg::*;
#(
    parameter int DEPTH = N,
    parameter int W     = DEF_DW,
    parameter int AW    = cw(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_idx,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_idx,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_idx] <= wr_data;
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/unpooler.sv
// unpooler: nearest-neighbour P x P upsampler, (M/P)^2 raster in, M^2 raster out.
// Ports: clk, master_rst (sync, active high), ce, io (unpooler_if.slave).
// Macro UNPOOL_ARGMAX_EN: max-unpooling, only the idx_in position carries the value.
module unpooler
    import unpool_pkg::*;
#(
    parameter int M         = 4,
    parameter int P         = 2,
    parameter int dataWidth = 16
) (
    input  logic      clk,
    input  logic      master_rst,
    input  logic      ce,
    unpooler_if.slave io
);

    localparam int NC = M / P;
    localparam int CW = cw(NC);
    localparam int RW = cw(P);
    localparam int OW = cw(M);

    localparam logic [0:0]    ST_FILL   = FILL;
    localparam logic [0:0]    ST_REPLAY = REPLAY;
    localparam logic [CW-1:0] COL_LAST  = CW'(NC - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(P - 1);
    localparam logic [OW-1:0] ROW_LAST  = OW'(M - 1);

`ifdef UNPOOL_ARGMAX_EN
    localparam int EW = $bits(entry_t);
`else
    localparam int EW = dataWidth;
`endif

    logic [0:0]    state;
    logic [CW-1:0] in_col;
    logic [CW-1:0] wr_col;
    logic [RW-1:0] rep_c;
    logic [RW-1:0] rep_r;
    logic [OW-1:0] out_row;
    logic          vld_r;
    logic [EW-1:0] out_reg;
    logic [EW-1:0] rd_ent;
    logic [EW-1:0] wr_ent;
    logic [EW-1:0] cur;
    logic          last_c;
    logic          last_col;
    logic          last_r;
    logic          vld;
    logic          in_rdy;
    logic          in_xfer;
    logic          out_xfer;

    assign last_c   = rep_c == REP_LAST;
    assign last_col = in_col == COL_LAST;
    assign last_r   = rep_r == REP_LAST;

    assign vld = !master_rst & ((state == ST_REPLAY) | vld_r);

    // A new input may land on the very transfer that retires the last copy,
    // including the final replay row, so rows and frames chain without bubbles.
    always_comb begin
        in_rdy = 1'b0;
        if (ce && !master_rst) begin
            unique case (state)
                ST_FILL:
                    in_rdy = !vld_r |
                             (io.out_ready & last_c & (!last_col | last_r));
                default:
                    in_rdy = io.out_ready & last_c & last_col & last_r;
            endcase
        end
    end

    assign in_xfer  = io.in_valid & in_rdy;
    assign out_xfer = vld & io.out_ready & ce;

    // Column the incoming value belongs to: the next one if a copy is retiring.
    assign wr_col = vld ? (last_col ? '0 : in_col + CW'(1)) : in_col;

`ifdef UNPOOL_ARGMAX_EN
    assign wr_ent = {io.idx_in, io.data_in};
`else
    assign wr_ent = io.data_in;
`endif

    unpool_line_buf #(
        .DEPTH (NC),
        .W     (EW),
        .AW    (CW)
    ) u_buf (
        .clk     (clk),
        .we      (in_xfer),
        .wr_idx  (wr_col),
        .wr_data (wr_ent),
        .rd_idx  (in_col),
        .rd_data (rd_ent)
    );

    assign cur = (state == ST_REPLAY) ? rd_ent : out_reg;

`ifdef UNPOOL_ARGMAX_EN
    entry_t           ent;
    logic [IDX_W-1:0] sel;

    assign ent = entry_t'(cur);
    assign sel = IDX_W'(int'(rep_r) * P + int'(rep_c));
    assign io.data_out = (master_rst || ent.idx != sel) ? '0 : ent.value;
`else
    assign io.data_out = master_rst ? '0 : cur;
`endif

    assign io.in_ready = in_rdy;
    assign io.valid_op = vld;
    assign io.end_op   = vld & (out_row == ROW_LAST) & last_col & last_c;

    always_ff @(posedge clk) begin
        if (master_rst) begin
            state   <= ST_FILL;
            in_col  <= '0;
            rep_c   <= '0;
            rep_r   <= '0;
            out_row <= '0;
            vld_r   <= 1'b0;
            out_reg <= '0;
        end else if (ce) begin
            if (in_xfer) begin
                out_reg <= wr_ent;
                vld_r   <= 1'b1;
            end else if (out_xfer && last_c) begin
                vld_r   <= 1'b0;
            end
            if (out_xfer) begin
                rep_c <= last_c ? '0 : rep_c + RW'(1);
                if (last_c) begin
                    in_col <= last_col ? '0 : in_col + CW'(1);
                    if (last_col) begin
                        out_row <= (out_row == ROW_LAST) ? '0 : out_row + OW'(1);
                        rep_r   <= last_r ? '0 : rep_r + RW'(1);
                        state   <= last_r ? ST_FILL : ST_REPLAY;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_unpooler.sv
// tb_unpooler: directed vectors for the unpooler (M=4, P=2, 16-bit data),
// plus hand-written reset, latency and clock-enable sequences.
`timescale 1ns/1ps
module tb_unpooler;
    import unpool_pkg::*;

    logic clk = 1'b0;
    logic master_rst;
    logic ce;

    always #5 clk = ~clk;

    unpooler_if #(.DW(16)) io();

    unpooler #(
        .M         (4),
        .P         (2),
        .dataWidth (16)
    ) dut (
        .clk        (clk),
        .master_rst (master_rst),
        .ce         (ce),
        .io         (io)
    );

    typedef struct packed {
        int               nin;
        logic [7:0][15:0] din;
        logic [7:0][1:0]  idx;
        int               nexp;
        logic [31:0][15:0] exp;
        bit               tog;
        bit               gaps;
        bit               bubble;
        bit               ce_gap;
    } vec_t;

    int n_run  = 0;
    int n_fail = 0;

    int e1[16] = '{1, 1, 2, 2, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 4, 4};
    int e2[16] = '{5, 5, 6, 6, 5, 5, 6, 6, 7, 7, 8, 8, 7, 7, 8, 8};
    int e3[16] = '{10, 10, 20, 20, 10, 10, 20, 20, 30, 30, 40, 40, 30, 30, 40, 40};
    int e9[16] = '{9, 9, 8, 8, 9, 9, 8, 8, 7, 7, 6, 6, 7, 7, 6, 6};
    int ea[16] = '{1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 4};

    vec_t vecs[4];
    int   nvec;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        n_run++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int pi, oi, cyc, gap;
        bit seen, stall;
        logic [15:0] hold;
        pi = 0; oi = 0; cyc = 0; gap = 0;
        seen = 0; stall = 0; hold = '0;
        while (oi < v.nexp && cyc < 400) begin
            @(negedge clk);
            ce = !(v.ce_gap && oi == 5 && gap < 3);
            if (!ce) gap++;
            io.in_valid = (pi < v.nin) && !(v.gaps && (cyc % 3 == 1));
            io.data_in  = (pi < v.nin) ? v.din[pi] : '0;
`ifdef UNPOOL_ARGMAX_EN
            io.idx_in   = (pi < v.nin) ? v.idx[pi] : '0;
`endif
            io.out_ready = v.tog ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (stall) check("stall_hold", io.data_out, hold);
            if (!ce) check("ce_in_ready", io.in_ready, 0);
            if (v.bubble && seen) check("no_bubble", io.valid_op, 1);
            if (io.valid_op) seen = 1;
            if (io.valid_op && io.out_ready && ce) begin
                check("data", io.data_out, v.exp[oi]);
                check("end_op", io.end_op, (oi % 16 == 15));
                oi++;
            end
            stall = io.valid_op && !(io.out_ready && ce);
            hold  = io.data_out;
            if (io.in_valid && io.in_ready) pi++;
            cyc++;
        end
        if (oi < v.nexp) begin
            n_run++;
            n_fail++;
            $display("FAIL timeout: %0d of %0d outputs", oi, v.nexp);
        end
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        ce = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        master_rst   = 1'b1;
        ce           = 1'b1;
        io.in_valid  = 1'b0;
        io.data_in   = '0;
        io.out_ready = 1'b0;
`ifdef UNPOOL_ARGMAX_EN
        io.idx_in    = '0;
`endif

        // Reset cycle outputs.
        @(negedge clk);
        #1;
        check("rst_in_ready", io.in_ready, 0);
        check("rst_valid", io.valid_op, 0);
        check("rst_data", io.data_out, 0);
        check("rst_end", io.end_op, 0);
        @(posedge clk);
        @(negedge clk);
        master_rst   = 1'b0;
        io.out_ready = 1'b1;
        #1;
        check("idle_valid", io.valid_op, 0);
        check("idle_in_ready", io.in_ready, 1);

        // Latency: valid_op one cycle after the first input transfer.
        io.in_valid = 1'b1;
        io.data_in  = 16'h5;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        check("lat_valid", io.valid_op, 1);
        check("lat_data", io.data_out, 16'h5);

        // Reset while valid: outputs cleared in the reset cycle itself.
        @(negedge clk);
        master_rst = 1'b1;
        #1;
        check("rst2_valid", io.valid_op, 0);
        check("rst2_data", io.data_out, 0);
        @(posedge clk);
        @(negedge clk);
        master_rst = 1'b0;

`ifdef UNPOOL_ARGMAX_EN
        v = '0;
        v.nin = 4; v.nexp = 16; v.bubble = 1;
        for (int i = 0; i < 4; i++) begin
            v.din[i] = 16'(i + 1);
            v.idx[i] = 2'(i);
        end
        for (int i = 0; i < 16; i++) v.exp[i] = 16'(ea[i]);
        vecs[0] = v;
        v.tog = 1; v.gaps = 1; v.bubble = 0;
        vecs[1] = v;
        nvec = 2;
`else
        v = '0;
        v.nin = 4; v.nexp = 16; v.bubble = 1;
        for (int i = 0; i < 4; i++) v.din[i] = 16'(i + 1);
        for (int i = 0; i < 16; i++) v.exp[i] = 16'(e1[i]);
        vecs[0] = v;
        v.tog = 1; v.gaps = 1; v.bubble = 0;
        vecs[1] = v;
        v = '0;
        v.nin = 8; v.nexp = 32; v.bubble = 1;
        for (int i = 0; i < 8; i++) v.din[i] = 16'(i + 1);
        for (int i = 0; i < 16; i++) begin
            v.exp[i]      = 16'(e1[i]);
            v.exp[i + 16] = 16'(e2[i]);
        end
        vecs[2] = v;
        v = '0;
        v.nin = 4; v.nexp = 16; v.bubble = 1; v.ce_gap = 1;
        for (int i = 0; i < 4; i++) v.din[i] = 16'(10 * (i + 1));
        for (int i = 0; i < 16; i++) v.exp[i] = 16'(e3[i]);
        vecs[3] = v;
        nvec = 4;
`endif

        for (int k = 0; k < nvec; k++) run_vec(vecs[k]);

`ifndef UNPOOL_ARGMAX_EN
        // Reset after five output transfers, then a fresh frame.
        v = '0;
        v.nin = 4; v.nexp = 5;
        for (int i = 0; i < 4; i++) v.din[i] = 16'(i + 1);
        for (int i = 0; i < 5; i++) v.exp[i] = 16'(e1[i]);
        run_vec(v);
        @(negedge clk);
        master_rst = 1'b1;
        #1;
        check("rst3_valid", io.valid_op, 0);
        check("rst3_in_ready", io.in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        master_rst = 1'b0;
        v = '0;
        v.nin = 4; v.nexp = 16; v.bubble = 1;
        for (int i = 0; i < 4; i++) v.din[i] = 16'(9 - i);
        for (int i = 0; i < 16; i++) v.exp[i] = 16'(e9[i]);
        run_vec(v);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
